instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the decode stage: accepts decoded RV32I instruction fields over a valid/ready handshake and packs them into 32-bit instruction words.
- Range-checks each immediate, then streams each legal word with its target instruction-memory address into a 2-entry output buffer.
- Sits between the test or boot loader and the instruction-memory write port, and is used to build program images for the core.

Parameters:
- ADDR_W, 10, log2 of image capacity in words; the image holds 2^ADDR_W words.
- BASE_ADDR, 32'h0000_0000, byte address of the first emitted word; must be 4-byte aligned.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse: flushes the buffer, resets the word index to 0, enters RUN.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle this cycle.
- opcode  in  7  instruction opcode.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  function-3 field.
- funct7  in  7  function-7 field.
- imm  in  32  signed immediate, in byte units for branch and jump.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  memory side accepts the head.
- out_addr  out  32  byte address of the head word.
- out_instr  out  32  encoded instruction word.
- err  out  1  one-cycle pulse when an accepted bundle is rejected.
- err_code  out  2  01 illegal opcode, 10 imm out of range, 11 imm misaligned; holds its last value.
- words  out  ADDR_W+1  count of legal words accepted since start.

Behaviour:
- Reset (async, any state): state IDLE, buffer empty.
  - Outputs: out_valid=0, out_addr=0, out_instr=0, in_ready=0, err=0, err_code=00, words=0.
- States:
  - IDLE: in_ready=0. start leads to RUN.
  - RUN: in_ready = !start && buffer count<2. When words reaches 2^ADDR_W, go to DONE.
  - DONE: in_ready=0; the buffer still drains. start leads to RUN.
  - start in RUN or DONE flushes the buffer, sets words=0 and re-enters RUN.
- A transfer occurs when in_valid && in_ready at a rising edge. start in the same cycle wins; in_ready is forced 0.
- Encoding (combinational on inputs, registered into the buffer):
  - R 0110011: {funct7,rs2,rs1,funct3,rd,op}.
  - I 0010011/0000011/1100111: {imm[11:0],rs1,funct3,rd,op}. imm must fit signed 12 bits.
  - S 0100011: {imm[11:5],rs2,rs1,funct3,imm[4:0],op}. imm must fit signed 12 bits.
  - B 1100011: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}. imm must fit signed 13 bits; imm[0] must be 0.
  - U 0110111/0010111: {imm[31:12],rd,op}. imm[11:0] must be 0, else code 11.
  - J 1101111: {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}. imm must fit signed 21 bits; imm[0] must be 0.
  - Any other opcode: code 01.
- Error priority: 01, then 11, then 10.
  - A rejected bundle is consumed but not buffered; words and the address do not advance.
  - err is high in the cycle after acceptance.
- Legal word: written into the buffer with out_addr = BASE_ADDR + 4*words, then words increments.
  - Latency: accepted at edge N gives out_valid visible after edge N, i.e. one cycle.
- Output handshake:
  - Head leaves on out_valid && out_ready.
  - out_addr and out_instr hold stable while out_valid && !out_ready.
  - Order is preserved.
  - Simultaneous push and pop on a full buffer is not possible, since in_ready=0 when full. On a 1-entry buffer, simultaneous push and pop keeps count at 1.
- Full throughput (one word per cycle) when out_ready is held high.
- Address wrap never occurs; DONE blocks further input.

Test Plan:
- start, then addi x1,x0,5 (op 0010011, rd=1, f3=0, imm=5) -> out_instr=0x00500093, out_addr=BASE_ADDR, words=1.
- sw x2,8(x1) (op 0100011, rs1=1, rs2=2, f3=2, imm=8) -> 0x0020A423. Then beq x1,x2,-4 (op 1100011, imm=-4) -> 0xFE208EE3 at BASE+4.
- jal x1 with imm=3 -> err=1, err_code=11, no output, words unchanged. Then jal x1,8 -> 0x008000EF. lui imm=0x12345001 -> err_code=11. addi imm=2048 -> err_code=10.
- out_ready=0 for 6 cycles while 3 bundles are offered back-to-back -> in_ready drops after 2 are buffered. Head holds stable; with out_ready=1, all 3 emerge in order at consecutive addresses.
- ADDR_W=2: 4 legal words -> DONE, in_ready=0. A 5th offer waits. start -> words=0, next word at BASE_ADDR.
- Assert rst with 2 words buffered -> out_valid=0 and words=0 immediately (async), state IDLE. in_ready stays 0 until start.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-to-word encoder: range-checks immediates, then streams each legal
// word with its image byte address through a 2-entry output buffer.
module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_addr,
  output logic [31:0]       out_instr,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   words,
  output logic [1:0]        dbg_state
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] E_NONE   = 2'b00;
  localparam logic [1:0] E_OPCODE = 2'b01;
  localparam logic [1:0] E_RANGE  = 2'b10;
  localparam logic [1:0] E_ALIGN  = 2'b11;

  localparam logic [ADDR_W:0] CAPACITY = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [1:0][31:0]  buf_addr_q, buf_addr_d;
  logic [1:0][31:0]  buf_instr_q, buf_instr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0] enc_word;
  logic [1:0]  enc_code;
  logic        fits12, fits13, fits21;
  logic        accept, push, pop;

  // A field bundle that decodes to a legal opcode fits signed N bits when all
  // bits from N-1 upward are copies of the sign.
  always_comb begin
    fits12   = (&imm[31:11]) | ~(|imm[31:11]);
    fits13   = (&imm[31:12]) | ~(|imm[31:12]);
    fits21   = (&imm[31:20]) | ~(|imm[31:20]);
    enc_word = '0;
    enc_code = E_NONE;
    case (opcode)
      OP_R: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits12) enc_code = E_RANGE;
      end
      OP_STORE: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits12) enc_code = E_RANGE;
      end
      OP_BRANCH: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])       enc_code = E_ALIGN;
        else if (!fits13) enc_code = E_RANGE;
      end
      OP_LUI, OP_AUIPC: begin
        enc_word = {imm[31:12], rd, opcode};
        if (|imm[11:0]) enc_code = E_ALIGN;
      end
      OP_JAL: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])       enc_code = E_ALIGN;
        else if (!fits21) enc_code = E_RANGE;
      end
      default: enc_code = E_OPCODE;
    endcase
  end

  // Handshakes: a bundle transfers on a rising edge where in_valid && in_ready;
  // the buffer head leaves on a rising edge where out_valid && out_ready, and
  // out_addr/out_instr stay stable while out_valid is held without out_ready.
  assign in_ready  = (state_q == S_RUN) && !start && (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && (enc_code == E_NONE);
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_d     = state_q;
    buf_addr_d  = buf_addr_q;
    buf_instr_d = buf_instr_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    words_d     = words_q;
    err_d       = accept && (enc_code != E_NONE);
    err_code_d  = err_d ? enc_code : err_code_q;
    if (start) begin
      state_d  = S_RUN;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
      words_d  = '0;
    end else begin
      if (push) begin
        buf_addr_d[wr_ptr_q]  = BASE_ADDR + (32'(words_q) << 2);
        buf_instr_d[wr_ptr_q] = enc_word;
        wr_ptr_d              = ~wr_ptr_q;
        words_d               = words_q + 1'b1;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      count_d = count_q + {1'b0, push} - {1'b0, pop};
      if ((state_q == S_RUN) && (words_d == CAPACITY)) state_d = S_DONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      buf_addr_q  <= '0;
      buf_instr_q <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
      words_q     <= '0;
      err_q       <= 1'b0;
      err_code_q  <= E_NONE;
    end else begin
      state_q     <= state_d;
      buf_addr_q  <= buf_addr_d;
      buf_instr_q <= buf_instr_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      words_q     <= words_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign out_addr  = out_valid ? buf_addr_q[rd_ptr_q]  : '0;
  assign out_instr = out_valid ? buf_instr_q[rd_ptr_q] : '0;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign words     = words_q;
  assign dbg_state = state_q;

endmodule
